// File: rtl/priority_scan_engine.sv
// Sequential priority scanner: takes one request vector per job and emits
// the index of every set bit in priority order, one per output handshake.
module priority_scan_engine #(
    parameter int              WIDTH     = 16,
    parameter int              OUT_W     = 8,
    parameter logic [OUT_W-1:0] NONE_CODE = 8'hF0,
    parameter bit              MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [OUT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        NONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [OUT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   pick_mask;
    logic               single;

    // Later matches overwrite earlier ones, so scan order sets priority.
    always_comb begin
        int j;
        pick_idx  = '0;
        pick_mask = '0;
        j         = 0;
        for (int i = 0; i < WIDTH; i++) begin
            j = MSB_FIRST ? i : (WIDTH - 1 - i);
            if (work_q[j]) begin
                pick_idx     = OUT_W'(j);
                pick_mask    = '0;
                pick_mask[j] = 1'b1;
            end
        end
    end

    assign single = (work_q != '0) &&
                    ((work_q & (work_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        if (flush) begin
            state_d = IDLE;
            work_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_d  = in_vec;
                        count_d = '0;
                        state_d = (in_vec != '0) ? EMIT : NONE;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        work_d  = work_q & ~pick_mask;
                        count_d = count_q + OUT_W'(1);
                        if (single) state_d = IDLE;
                    end
                end
                NONE: begin
                    if (out_ready) begin
                        count_d = OUT_W'(1);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_idx   = (state_q == EMIT) ? pick_idx : NONE_CODE;
    assign out_last  = (state_q == NONE) || ((state_q == EMIT) && single);
    assign out_none  = (state_q == NONE);
    assign out_count = count_q;

endmodule

// File: tb/tb_priority_scan_engine.sv
// Bench for priority_scan_engine: one MSB-first and one LSB-first instance
// share stimulus; outputs are compared against a queue-based model.
module tb_priority_scan_engine;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [15:0] in_vec;

    logic       a_in_ready, a_valid, a_last, a_none;
    logic [7:0] a_idx, a_count;
    logic       b_in_ready, b_valid, b_last, b_none;
    logic [7:0] b_idx, b_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    priority_scan_engine #(.WIDTH(16), .OUT_W(8), .NONE_CODE(8'hF0),
                           .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_vec(in_vec),
        .out_valid(a_valid), .out_ready(out_ready), .out_idx(a_idx),
        .out_last(a_last), .out_none(a_none), .out_count(a_count)
    );

    priority_scan_engine #(.WIDTH(16), .OUT_W(8), .NONE_CODE(8'hF0),
                           .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_vec(in_vec),
        .out_valid(b_valid), .out_ready(out_ready), .out_idx(b_idx),
        .out_last(b_last), .out_none(b_none), .out_count(b_count)
    );

    typedef struct {
        logic [15:0] vec;
        int          rp;
        int          stall;
        int          exp_k;
        int          exp_first;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm, input int cnt);
        chk({nm, "_a_ready"}, a_in_ready, 1);
        chk({nm, "_a_valid"}, a_valid, 0);
        chk({nm, "_a_count"}, a_count, cnt);
        chk({nm, "_b_ready"}, b_in_ready, 1);
        chk({nm, "_b_valid"}, b_valid, 0);
        chk({nm, "_b_count"}, b_count, cnt);
    endtask

    // Run one job; model is the list of set-bit indices in each order.
    task automatic run_job(input logic [15:0] v, input int rp,
                           input int stall, output int first_a,
                           output int cnt_a);
        int qa[$];
        int qb[$];
        int done;
        int cyc;
        int ea, eb;
        for (int i = 15; i >= 0; i--) if (v[i]) qa.push_back(i);
        for (int i = 0; i < 16; i++) if (v[i]) qb.push_back(i);
        if (v == 16'h0) begin
            qa.push_back(240);
            qb.push_back(240);
        end
        first_a = -1;
        chk("accept_ready", a_in_ready, 1);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
        done = 0;
        cyc  = 0;
        while (qa.size() > 0 && cyc < 200) begin
            ea = qa[0];
            eb = qb[0];
            chk("a_valid", a_valid, 1);
            chk("a_idx", a_idx, ea);
            chk("a_last", a_last, qa.size() == 1);
            chk("a_none", a_none, v == 16'h0);
            chk("a_count", a_count, done);
            chk("a_in_ready", a_in_ready, 0);
            chk("b_valid", b_valid, 1);
            chk("b_idx", b_idx, eb);
            chk("b_last", b_last, qb.size() == 1);
            chk("b_none", b_none, v == 16'h0);
            chk("b_count", b_count, done);
            if (cyc == 0) first_a = int'(a_idx);
            out_ready = (cyc < stall) ? 1'b0
                      : ($urandom_range(0, 99) < rp);
            in_vec = 16'($urandom);
            step();
            if (out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                done++;
            end
            cyc++;
        end
        if (qa.size() > 0) chk("job_timeout", 1, 0);
        out_ready = 1'b0;
        chk_idle("job_end", done);
        cnt_a = int'(a_count);
    endtask

    initial begin
        int fa, ca;
        logic [15:0] rv;

        tbl[0] = '{16'h8001, 100, 0,  2, 15};
        tbl[1] = '{16'h0000, 100, 0,  1, 240};
        tbl[2] = '{16'h0A00, 100, 3,  2, 11};
        tbl[3] = '{16'hFFFF, 100, 0, 16, 15};
        tbl[4] = '{16'h00F0,  50, 0,  4, 7};
        tbl[5] = '{16'h0001, 100, 0,  1, 0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_vec = '0;
        step();
        step();
        rst_n = 1'b1;
        chk_idle("reset", 0);
        chk("reset_a_idx", a_idx, 8'hF0);
        chk("reset_a_last", a_last, 0);
        chk("reset_a_none", a_none, 0);

        foreach (tbl[t]) begin
            run_job(tbl[t].vec, tbl[t].rp, tbl[t].stall, fa, ca);
            chk("tbl_count", ca, tbl[t].exp_k);
            chk("tbl_first", fa, tbl[t].exp_first);
        end

        // Flush after the first transfer discards the concurrent handshake.
        in_valid = 1'b1; in_vec = 16'h00F0;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_first_idx", a_idx, 7);
        step();
        chk("fl_second_idx", a_idx, 6);
        flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk_idle("flush", 1);
        run_job(16'h0002, 100, 0, fa, ca);
        chk("post_flush_first", fa, 1);
        chk("post_flush_count", ca, 1);

        // Flush in IDLE beats a simultaneous input handshake.
        flush = 1'b1; in_valid = 1'b1; in_vec = 16'h1234;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_idle("flush_idle", 1);

        // Reset mid-job discards the job.
        in_valid = 1'b1; in_vec = 16'h0F0F;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        chk_idle("mid_reset", 0);
        chk("mid_reset_idx", a_idx, 8'hF0);

        for (int r = 0; r < 40; r++) begin
            rv = 16'($urandom) & 16'($urandom);
            if (r % 8 == 3) rv = 16'h0;
            run_job(rv, 60, 0, fa, ca);
            chk("rand_count", ca, $countones(rv) == 0 ? 1 : $countones(rv));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
